// File: rtl/lcd_rgb_rx.sv
// Receiver for the parallel RGB LCD bus: recovers pixel coordinates,
// measures active width/height and tracks format lock.
module lcd_rgb_rx #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 480,
  parameter int SYNC_POL  = 0,
  parameter int LOCK_FRMS = 2
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic [23:0] rgb_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        frame_done,
  output logic [10:0] meas_width,
  output logic [10:0] meas_height,
  output logic        locked,
  output logic        fmt_err
);

  localparam logic [1:0] SEEK    = 2'd0;
  localparam logic [1:0] WAIT_DE = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;

  localparam logic [10:0] H_EXP = 11'(H_ACTIVE);
  localparam logic [10:0] V_EXP = 11'(V_ACTIVE);
  localparam logic [10:0] SAT   = 11'd2047;
  localparam logic [7:0]  LK_N  = 8'(LOCK_FRMS);

  // inactive sync level; sync regs reset here so no false edge on release
  localparam logic IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == SAT) ? v : v + 11'd1;
  endfunction

  logic [23:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        de_q;
  logic        hs_d;
  logic        vs_d;
  logic        de_d;

  logic [1:0]  state;
  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic        hs_seen;
  logic        line_acc;
  logic [7:0]  fcnt;

  logic        hs_lead;
  logic        vs_lead;
  logic        de_rise;
  logic        de_fall;
  logic        in_frame;
  logic        close_line;
  logic        line_bad;
  logic [10:0] y_close;
  logic        frame_end;
  logic        height_bad;
  logic        frame_bad;
  logic        pix_take;
  logic [10:0] cur_x;
  logic        hit;
  logic [7:0]  fcnt_inc;

  // input register plus one delayed copy for edge detection
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_q <= '0;
      hs_q  <= IDLE;
      vs_q  <= IDLE;
      de_q  <= 1'b0;
      hs_d  <= IDLE;
      vs_d  <= IDLE;
      de_d  <= 1'b0;
    end else begin
      rgb_q <= rgb_in;
      hs_q  <= hsync_in;
      vs_q  <= vsync_in;
      de_q  <= de_in;
      hs_d  <= hs_q;
      vs_d  <= vs_q;
      de_d  <= de_q;
    end
  end

  // edge decode and line/frame close decisions for this cycle
  always_comb begin
    hs_lead    = (hs_q ^ IDLE) & ~(hs_d ^ IDLE);
    vs_lead    = (vs_q ^ IDLE) & ~(vs_d ^ IDLE);
    de_rise    = de_q & ~de_d;
    de_fall    = ~de_q & de_d;
    in_frame   = (state != SEEK);
    close_line = (state == ACTIVE) & (de_fall | vs_lead);
    line_bad   = (x_cnt != H_EXP) | de_q | ~hs_seen;
    y_close    = close_line ? sat_inc(y_cnt) : y_cnt;
    frame_end  = vs_lead & in_frame & (y_close != 11'd0);
    height_bad = (y_close != V_EXP);
    frame_bad  = line_acc | (close_line & line_bad) | height_bad;
    pix_take   = de_q & ~vs_lead &
                 ((state == ACTIVE) | ((state == WAIT_DE) & de_rise));
    cur_x      = (state == ACTIVE) ? x_cnt : 11'd0;
    hit        = pix_take & (cur_x < H_EXP) & (y_cnt < V_EXP);
    fcnt_inc   = (fcnt == 8'hFF) ? fcnt : fcnt + 8'd1;
  end

  // sync FSM, pixel/line counters and frame-quality tracking
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= SEEK;
      x_cnt    <= '0;
      y_cnt    <= '0;
      hs_seen  <= 1'b0;
      line_acc <= 1'b0;
      fcnt     <= '0;
    end else begin
      if (pix_take)
        x_cnt <= sat_inc(cur_x);

      if (vs_lead)
        y_cnt <= '0;
      else if (close_line)
        y_cnt <= sat_inc(y_cnt);

      if (close_line)
        hs_seen <= hs_lead;
      else if (hs_lead)
        hs_seen <= 1'b1;

      if (vs_lead)
        line_acc <= 1'b0;
      else if (close_line & line_bad)
        line_acc <= 1'b1;

      if (frame_end)
        fcnt <= frame_bad ? 8'd0 : fcnt_inc;

      if (vs_lead) begin
        state <= WAIT_DE;
      end else begin
        unique case (state)
          WAIT_DE: if (de_rise) state <= ACTIVE;
          ACTIVE:  if (de_fall) state <= WAIT_DE;
          default: state <= state;
        endcase
      end
    end
  end

  // registered outputs: pixel stream, measurements and status
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      locked      <= 1'b0;
      fmt_err     <= 1'b0;
    end else begin
      pix_valid  <= hit;
      sof        <= hit & (cur_x == 11'd0) & (y_cnt == 11'd0);
      eol        <= hit & (cur_x == H_EXP - 11'd1);
      frame_done <= frame_end;
      if (hit) begin
        pix_data <= rgb_q;
        pix_x    <= cur_x[9:0];
        pix_y    <= y_cnt[9:0];
      end
      if (close_line)
        meas_width <= x_cnt;
      if (frame_end) begin
        meas_height <= y_close;
        locked      <= ~frame_bad & (fcnt_inc >= LK_N);
      end
      // frame_done restarts the error flag with the height verdict
      if (frame_end)
        fmt_err <= height_bad;
      else if (close_line & line_bad)
        fmt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Randomized bench for lcd_rgb_rx: pixel scoreboard plus
// per-frame measurement/lock model.
module tb_lcd_rgb_rx;

  localparam int H = 16;
  localparam int V = 6;

  logic        clk_in = 1'b0;
  logic        sys_rst_n;
  logic [23:0] rgb_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        sof;
  logic        eol;
  logic        frame_done;
  logic [10:0] meas_width;
  logic [10:0] meas_height;
  logic        locked;
  logic        fmt_err;

  lcd_rgb_rx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(0), .LOCK_FRMS(2)
  ) dut (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .rgb_in(rgb_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x),
    .pix_y(pix_y), .sof(sof), .eol(eol), .frame_done(frame_done),
    .meas_width(meas_width), .meas_height(meas_height),
    .locked(locked), .fmt_err(fmt_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [23:0] d;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        s;
    logic        e;
  } pix_t;

  typedef struct packed {
    logic [10:0] w;
    logic [10:0] h;
    logic        lk;
    logic        fe;
  } fr_t;

  pix_t pq[$];
  fr_t  fq[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mark_cyc = -1;
  int n_fd = 0;
  int exp_fd = 0;

  bit synced = 0;
  int lk_cnt = 0;
  bit fe_carry = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // output monitor, sampled 1ns after the active edge
  always @(posedge clk_in) begin
    #1;
    if (sys_rst_n) begin
      if (pix_valid) begin
        if (pq.size() == 0) chk("pix_spurious", 1, 0);
        else chk("pix", {pix_data, pix_x, pix_y, sof, eol}, pq.pop_front());
        if (pix_data == 24'hA55A3C) chk("latency", cyc - mark_cyc, 2);
      end
      if (frame_done) begin
        n_fd++;
        if (fq.size() == 0) chk("fd_spurious", 1, 0);
        else chk("frame", {meas_width, meas_height, locked, fmt_err},
                 fq.pop_front());
      end
    end
  end

  // one pixel-clock cycle of bus activity; syncs are active-low
  task automatic drv(input bit vs, input bit hs, input bit de,
                     input logic [23:0] d);
    vsync_in = ~vs;
    hsync_in = ~hs;
    de_in    = de;
    rgb_in   = d;
    @(negedge clk_in);
  endtask

  function automatic logic [23:0] rnd_pix();
    logic [23:0] d;
    d = 24'($urandom);
    while (d == 24'hA55A3C) d = 24'($urandom);
    return d;
  endfunction

  // one frame: vsync, blanking, nl lines (line bad_l gets bad_w pixels).
  // coin: next vsync lands on the cycle DE drops on the last line.
  task automatic send_frame(input int nl, input int bad_l, input int bad_w,
                            input bit coin, input int rst_l, input int rst_c,
                            input int mk_l, input int mk_c);
    bit line_err;
    int last_w;
    int w;
    logic [23:0] d;
    line_err = 0;
    last_w = 0;
    repeat (3) drv(1, 0, 0, 0);
    synced = 1;
    repeat (2) drv(0, 0, 0, 0);
    repeat (2) drv(0, 1, 0, 0);
    repeat (2) drv(0, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      w = (l == bad_l) ? bad_w : H;
      if (w != H) line_err = 1;
      last_w = w;
      for (int c = 0; c < w; c++) begin
        d = rnd_pix();
        if (l == mk_l && c == mk_c) begin
          d = 24'hA55A3C;
          mark_cyc = cyc;
        end
        if (l == rst_l && c == rst_c) begin
          sys_rst_n = 1'b0;
          #1;
          chk("rst_pix", {pix_valid, pix_data, pix_x, pix_y, sof, eol}, 0);
          chk("rst_stat",
              {frame_done, meas_width, meas_height, locked, fmt_err}, 0);
          pq.delete();
          fq.delete();
          synced = 0;
          lk_cnt = 0;
          fe_carry = 0;
        end
        if (l == rst_l && c == rst_c + 3) sys_rst_n = 1'b1;
        if (synced && l < V && c < H)
          pq.push_back({d, 10'(c), 10'(l), c == 0 && l == 0, c == H - 1});
        drv(0, 0, 1, d);
      end
      if (coin && l == nl - 1) break;
      drv(0, 0, 0, 0);
      repeat (2) drv(0, 1, 0, 0);
      drv(0, 0, 0, 0);
    end
    if (!coin) begin
      repeat (2) drv(0, 0, 0, 0);
      if (synced) chk("fmt_sticky", fmt_err, fe_carry | line_err);
    end
    if (synced) begin
      bit good;
      bit lk;
      good = !line_err && nl == V;
      if (good) begin
        if (lk_cnt < 255) lk_cnt++;
      end else begin
        lk_cnt = 0;
      end
      lk = good && lk_cnt >= 2;
      fq.push_back({11'((last_w > 2047) ? 2047 : last_w), 11'(nl), lk,
                    nl != V});
      fe_carry = (nl != V);
      exp_fd++;
    end
  endtask

  task automatic good_frame();
    send_frame(V, -1, H, 0, -1, -1, -1, -1);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    vsync_in = 1'b1;
    hsync_in = 1'b1;
    de_in = 1'b0;
    rgb_in = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_pix", {pix_valid, pix_data, pix_x, pix_y, sof, eol}, 0);
    chk("reset_stat",
        {frame_done, meas_width, meas_height, locked, fmt_err}, 0);
    sys_rst_n = 1'b1;
    repeat (5) drv(0, 0, 0, 0);

    good_frame();
    send_frame(V, -1, H, 0, -1, -1, 3, 5);
    good_frame();
    send_frame(V, V - 1, H + 1, 0, -1, -1, -1, -1);
    good_frame();
    good_frame();
    send_frame(V - 1, -1, H, 0, -1, -1, -1, -1);
    send_frame(V + 2, -1, H, 0, -1, -1, -1, -1);
    send_frame(V, V - 1, 2100, 0, -1, -1, -1, -1);
    good_frame();
    good_frame();
    send_frame(V, -1, H, 1, -1, -1, -1, -1);
    send_frame(V, -1, H, 0, 2, 8, -1, -1);
    good_frame();
    good_frame();

    for (int i = 0; i < 8; i++) begin
      int nl;
      int bl;
      nl = V - 1 + int'($urandom_range(0, 2));
      bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      send_frame(nl, bl, int'($urandom_range(H - 2, H + 2)),
                 1'($urandom_range(0, 1)), -1, -1, -1, -1);
    end

    repeat (3) drv(1, 0, 0, 0);
    repeat (6) drv(0, 0, 0, 0);

    chk("pix_left", pq.size(), 0);
    chk("frame_left", fq.size(), 0);
    chk("fd_count", n_fd, exp_fd);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
